// File: rtl/piso_serializer.sv
// piso_serializer: MSB-first parallel-to-serial shifter with a valid/ready load port.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit after din[0].
module piso_serializer #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [width-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_done
);
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int FW = width + 1;
`else
    localparam int FW = width;
`endif
    localparam int CW = $clog2(width + 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t        r_state, w_next;
    logic [FW-1:0] r_shift, w_word;
    logic [CW-1:0] r_cnt;
    logic          r_done, w_last, w_adv, w_accept;
`ifdef PISO_SERIALIZER_PARITY_EN
    assign w_word = {din, ^din};
`else
    assign w_word = din;
`endif
    always_comb begin
        w_adv      = r_state == SHIFT && en;
        w_last     = r_cnt == CW'(FW - 1);
        load_ready = r_state == IDLE || (w_adv && w_last);
        w_accept   = load_valid && load_ready;
        w_next     = w_accept ? SHIFT : (w_adv && w_last) ? IDLE : r_state;
        dout_valid = r_state == SHIFT;
        dout       = dout_valid && r_shift[FW-1];
        frame_done = r_done;
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end
    // The counter parks on the last index so it never wraps, even for FW = 2**CW.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_adv && w_last;
            if (w_accept) begin
                r_shift <= w_word;
                r_cnt   <= '0;
            end else if (w_adv) begin
                r_shift <= r_shift << 1;
                r_cnt   <= w_last ? r_cnt : r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: table vectors, corner sequences and random traffic against a queue-based frame model.
module tb_piso_serializer;
    localparam int W = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = W + PAR;
    logic clk = 1'b0;
    logic rst, en, load_valid, load_ready, dout, dout_valid, frame_done;
    logic [W-1:0] din;
    logic [W-1:0] sipo = '0;
    int total = 0;
    int bad = 0;
    bit q[$];
    bit m_done = 1'b0;
    logic c_valid, c_dout, c_done;
    typedef struct {
        logic r, e, lv;
        logic [W-1:0] d;
        logic xv, xd, xdn;
    } vec_t;
    vec_t tv[10];

    always #5 clk = ~clk;

    piso_serializer #(.width(W)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .load_valid(load_valid),
        .load_ready(load_ready), .dout(dout), .dout_valid(dout_valid), .frame_done(frame_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, compare against the model mid-cycle, then advance the model.
    task automatic step(input logic r, input logic e, input logic lv, input logic [W-1:0] d);
        bit mv, md, mr, last;
        rst = r; en = e; load_valid = lv; din = d;
        @(negedge clk);
        mv = q.size() != 0;
        md = mv && q[0];
        last = q.size() == 1;
        mr = !mv || (e && last);
        c_valid = dout_valid; c_dout = dout; c_done = frame_done;
        chk("dout_valid", 32'(dout_valid), 32'(mv));
        chk("dout", 32'(dout), 32'(md));
        chk("load_ready", 32'(load_ready), 32'(mr));
        chk("frame_done", 32'(frame_done), 32'(m_done));
        if (e) sipo = {sipo[W-2:0], dout};
        @(posedge clk);
        if (r) begin
            q.delete();
            m_done = 1'b0;
        end else begin
            m_done = mv && e && last;
            if (mv && e) void'(q.pop_front());
            if (lv && mr) begin
                q.delete();
                for (int i = W - 1; i >= 0; i--) q.push_back(d[i]);
                if (PAR == 1) q.push_back(^d);
            end
        end
        #1;
    endtask

    initial begin
        int dones;
        logic [W-1:0] a5;
        rst = 1'b1; en = 1'b0; load_valid = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        step(1, 1, 1, 8'h3C);
        a5 = 8'hA5;
        tv[0] = '{r:0, e:1, lv:1, d:8'hA5, xv:0, xd:0, xdn:0};
        for (int i = 1; i <= 8; i++) tv[i] = '{r:0, e:1, lv:0, d:8'h00, xv:1, xd:a5[8-i], xdn:0};
        tv[9] = '{r:0, e:1, lv:0, d:8'h00, xv:(PAR == 1), xd:0, xdn:(PAR == 0)};
        for (int i = 0; i < 10; i++) begin
            step(tv[i].r, tv[i].e, tv[i].lv, tv[i].d);
            chk($sformatf("tbl%0d_valid", i), 32'(c_valid), 32'(tv[i].xv));
            chk($sformatf("tbl%0d_dout", i), 32'(c_dout), 32'(tv[i].xd));
            chk($sformatf("tbl%0d_done", i), 32'(c_done), 32'(tv[i].xdn));
            if (i == 8) chk("sipo_a5", 32'(sipo), 32'h0000_00A5);
        end
        repeat (3) step(0, 1, 0, 0);
        step(0, 1, 1, 8'hC3);
        dones = 0;
        for (int k = 0; k < 2 * FL; k++) begin
            step(0, (k % 2) == 0, 0, 0);
            dones += int'(c_done);
        end
        step(0, 1, 0, 0);
        chk("c3_done_count", 32'(dones + int'(c_done)), 32'd1);
        step(0, 1, 1, 8'h0F);
        dones = 0;
        for (int k = 0; k < 3 * FL; k++) begin
            step(0, 1, k < FL, 8'hF0);
            dones += int'(c_done);
        end
        chk("b2b_done_count", 32'(dones), 32'd2);
        step(0, 1, 1, 8'hFF);
        repeat (3) step(0, 1, 0, 0);
        step(1, 1, 1, 8'h81);
        dones = 0;
        repeat (3) begin
            step(0, 1, 0, 0);
            dones += int'(c_done);
        end
        chk("rst_abort_done", 32'(dones), 32'd0);
        chk("rst_abort_valid", 32'(c_valid), 32'd0);
        step(0, 1, 1, 8'hAA);
        repeat (3) step(0, 1, 1, 8'h55);
        repeat (FL - 3) step(0, 1, 0, 0);
        chk("ignore_55_sipo", 32'(sipo), 32'h0000_00AA);
        step(0, 1, 1, 8'h07);
        repeat (FL + 2) step(0, 1, 0, 0);
        for (int k = 0; k < 2000; k++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, W'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter: width, default 8, number of data bits per frame; legal range 2..32.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: en  input  1  bit-advance enable; the current serial bit is consumed on each rising edge with en=1.
REQ-005 SHALL have port: din  input  width  parallel word to transmit.
REQ-006 SHALL have port: load_valid  input  1  din holds a word offered for transmission.
REQ-007 SHALL have port: load_ready  output  1  serializer can accept a word this cycle.
REQ-008 SHALL have port: dout  output  1  serial data bit, MSB first.
REQ-009 SHALL have port: dout_valid  output  1  dout carries a frame bit.
REQ-010 SHALL have port: frame_done  output  1  one-cycle pulse after the last frame bit is consumed.

Function
REQ-011 SHALL implement two states: IDLE and SHIFT.
REQ-012 SHALL drive load_ready=1 in IDLE, and in SHIFT only when en=1 and the last frame bit is on dout; load_ready is 0 at all other times.
REQ-013 SHALL accept a word on a rising edge with load_valid=1 and load_ready=1: capture din, clear bit counter, enter or stay in SHIFT.
REQ-014 SHALL present din[width-1] on dout in the cycle after acceptance (latency 1), then din[width-2] ... din[0], each advancing only on an edge with en=1.
REQ-015 SHALL hold dout and the counter unchanged on edges with en=0; there is no timeout.
REQ-016 SHALL ensure that a SIPO shift register clocked with the same clk/en and fed dout holds din in its parallel output (bit i = din[i]) after width consumed bits.
REQ-017 SHALL drive dout_valid=1 exactly while in SHIFT, and dout=0 whenever dout_valid=0.
REQ-018 SHALL, on consuming the last frame bit, pulse frame_done=1 for the following cycle and go to IDLE, unless a new word is accepted on the same edge.
REQ-019 SHALL, on a same-edge accept (REQ-012), stay in SHIFT and present the new word's MSB next cycle with no idle gap; frame_done still pulses.
REQ-020 SHALL ignore en in IDLE, and ignore load_valid whenever load_ready=0 (din not sampled).
REQ-021 SHALL size the bit counter to ceil(log2(width+1)) bits, with no wrap within a frame.

Reset
REQ-022 SHALL, on any edge with rst=1, enter IDLE and clear the shift register and counter; dout=0, dout_valid=0, frame_done=0, load_ready=1 from the next cycle.
REQ-023 SHALL let rst abort a frame in progress: remaining bits are discarded, no frame_done is issued, and a load on the same edge is ignored.
REQ-024 SHALL give rst priority over en and load_valid.

Configuration
REQ-025 SHALL use macro PISO_SERIALIZER_PARITY_EN to control the parity bit.
REQ-026 SHALL, when the macro is defined, append one even-parity bit (XOR of all width data bits) after din[0], making the frame width+1 bits; "last frame bit" means the parity bit.
REQ-027 SHALL, when the macro is undefined, use a frame of exactly width bits with no parity logic present.

Verification
REQ-028 SHALL cover: width=8, load 0xA5, en held 1 -> dout 1,0,1,0,0,1,0,1 on cycles 1..8; frame_done at cycle 9; a SIPO receiver holds 0xA5.
REQ-029 SHALL cover: load 0xC3, en toggling 1,0,1,0 -> each bit held for two cycles; 16 cycles total; dout_valid continuously 1.
REQ-030 SHALL cover: load_valid held with 0x0F then 0xF0 -> 16 back-to-back bits 00001111 11110000, no gap, two frame_done pulses.
REQ-031 SHALL cover: rst asserted after 3 bits of 0xFF -> next cycle dout_valid=0, dout=0, load_ready=1, no frame_done.
REQ-032 SHALL cover: load_valid=1 with 0x55 mid-frame while load_ready=0 -> ignored; the current frame completes unchanged.
REQ-033 SHALL cover: with PISO_SERIALIZER_PARITY_EN defined, load 0x07 -> 9 bits 00000111 then parity 1; frame_done after the 9th bit.
